// File: rtl/e1_crc4_if.sv
`default_nettype none
// ============================================================================
// Module      : e1_crc4_if
// Description : Serial bit stream and CRC-4 remainder bundle for the E1
//               CRC-4 generator/checker. The framer side is the master and
//               the CRC block is the slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface e1_crc4_if;
    logic       in_bit;
    logic       in_first;
    logic       in_valid;
    logic [3:0] out_crc4;

    modport master (
        output in_bit,
        output in_first,
        output in_valid,
        input  out_crc4
    );

    modport slave (
        input  in_bit,
        input  in_first,
        input  in_valid,
        output out_crc4
    );
endinterface
`default_nettype wire

// File: rtl/e1_crc4.sv
`default_nettype none
// ============================================================================
// Module      : e1_crc4
// Description : Bit-serial CRC-4 (x^4 + x + 1) generator/checker for E1
//               G.704 multiframes. Zero initial value, MSB-first, block
//               restart on in_first with no dead cycle. out_crc4[3] is C1.
// Revision    : 1.0 - initial release
// ============================================================================
module e1_crc4 (
    input  wire             clk,
    input  wire             rst,
    e1_crc4_if.slave        bus
);

    // Feedback taps for x^4 + x + 1 (the x^4 term is implicit in the shift).
    localparam logic [3:0] c_POLY_TAPS = 4'b0011;

    logic [3:0] r_crc;
    logic [3:0] w_base;
    logic       w_fb;
    logic [3:0] w_crc_next;

    // Next remainder: restart from zero on the first bit of a block, then
    // one LFSR step with the incoming bit folded into the feedback.
    always_comb begin
        w_base     = bus.in_first ? 4'b0000 : r_crc;
        w_fb       = bus.in_bit ^ w_base[3];
        w_crc_next = {w_base[2:0], 1'b0} ^ (w_fb ? c_POLY_TAPS : 4'b0000);
    end

    // Remainder register: load only on a valid bit so stalled (possibly
    // unknown) inputs never reach the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crc <= 4'b0000;
        end else if (bus.in_valid) begin
            r_crc <= w_crc_next;
        end
    end

    assign bus.out_crc4 = r_crc;

endmodule
`default_nettype wire

// File: tb/tb_e1_crc4.sv
`default_nettype none
// ============================================================================
// Module      : tb_e1_crc4
// Description : Self-checking bench for e1_crc4. Reference remainder is
//               computed by polynomial long division of M(x)*x^4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_e1_crc4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    e1_crc4_if bus ();

    e1_crc4 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Bits of the current block, first bit at index 0 (highest order).
    bit q_msg[$];

    // Remainder of M(x)*x^4 mod x^4+x+1 by long division over the
    // augmented message.
    function automatic logic [3:0] ref_crc(input bit m[$]);
        logic [4:0] acc;
        bit         aug[$];
        aug = m;
        for (int k = 0; k < 4; k++) aug.push_back(1'b0);
        acc = 5'd0;
        foreach (aug[i]) begin
            acc = {acc[3:0], aug[i]};
            if (acc[4]) acc = acc ^ 5'b10011;
        end
        return acc[3:0];
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; model follows, output checked #1 after the edge.
    task automatic drive(input logic b, input logic f, input logic v, input string tag);
        @(negedge clk);
        bus.in_bit   = b;
        bus.in_first = f;
        bus.in_valid = v;
        @(posedge clk);
        #1;
        if (v === 1'b1) begin
            if (f === 1'b1) q_msg.delete();
            q_msg.push_back(b);
        end
        check(tag, bus.out_crc4, ref_crc(q_msg));
    endtask

    // Stall cycle with junk (sometimes unknown) on bit/first.
    task automatic stall(input logic [3:0] hold_val);
        logic jb, jf;
        jb = ($urandom_range(0, 3) == 0) ? 1'bx : 1'($urandom);
        jf = ($urandom_range(0, 3) == 0) ? 1'bx : 1'($urandom);
        drive(jb, jf, 1'b0, "stall_model");
        check("stall_hold", bus.out_crc4, hold_val);
    endtask

    task automatic send_word(input logic [31:0] w, input int stall_pct, input string tag);
        for (int i = 31; i >= 0; i--) begin
            while ($urandom_range(0, 99) < stall_pct) stall(bus.out_crc4);
            drive(w[i], (i == 31), 1'b1, tag);
            if (i == 24) check({tag, "_after8"}, bus.out_crc4, 4'hE);
        end
        check({tag, "_final"}, bus.out_crc4, 4'hF);
    endtask

    initial begin
        logic [31:0] word;
        word         = 32'h0BADBABE;
        rst          = 1'b1;
        bus.in_bit   = 1'b0;
        bus.in_first = 1'b0;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", bus.out_crc4, 4'h0);
        @(negedge clk);
        rst = 1'b0;

        // Single bit followed by zeros
        drive(1'b1, 1'b1, 1'b1, "single");
        check("single_0", bus.out_crc4, 4'h3);
        drive(1'b0, 1'b0, 1'b1, "single");
        check("single_1", bus.out_crc4, 4'h6);
        drive(1'b0, 1'b0, 1'b1, "single");
        check("single_2", bus.out_crc4, 4'hC);
        drive(1'b0, 1'b0, 1'b1, "single");
        check("single_3", bus.out_crc4, 4'hB);

        // Word vector, no stalls, then with stalls
        send_word(word, 0, "word");
        send_word(word, 40, "stallword");

        // Restart after arbitrary history
        for (int i = 0; i < 10; i++) drive(1'($urandom), (i == 0), 1'b1, "history");
        drive(1'b1, 1'b1, 1'b1, "restart");
        check("restart_0", bus.out_crc4, 4'h3);
        drive(1'b0, 1'b0, 1'b1, "restart");
        check("restart_1", bus.out_crc4, 4'h6);
        drive(1'b0, 1'b0, 1'b1, "restart");
        check("restart_2", bus.out_crc4, 4'hC);
        drive(1'b0, 1'b0, 1'b1, "restart");
        check("restart_3", bus.out_crc4, 4'hB);

        // Asynchronous reset mid-block
        for (int i = 31; i >= 20; i--) drive(word[i], (i == 31), 1'b1, "pre_reset");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", bus.out_crc4, 4'h0);
        q_msg.delete();
        bus.in_bit   = 1'b1;
        bus.in_first = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("reset_hold", bus.out_crc4, 4'h0);
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        send_word(word, 0, "post_reset");

        // Randomised blocks of arbitrary length with random stalls
        for (int blk = 0; blk < 20; blk++) begin
            int len;
            len = $urandom_range(1, 300);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 9) == 0) stall(bus.out_crc4);
                drive(1'($urandom), (i == 0), 1'b1, "random");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
